// File: rtl/myo_spi_scheduler.sv
// Round-robin poll scheduler for one myocontrol SPI port: each period tick walks the
// latched motor mask, framing every transfer with slave select, setup, start, done/timeout and gap.
module myo_spi_scheduler #(
    parameter int NUMBER_OF_MOTORS = 9,
    parameter int SETUP_CYCLES     = 4,
    parameter int GAP_CYCLES       = 50,
    parameter int TIMEOUT_CYCLES   = 2000,
    localparam int IW = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUMBER_OF_MOTORS-1:0] motor_mask,
    input  logic [31:0]                 update_period,
    input  logic                        power_sense_n,
    input  logic                        spi_done,
    input  logic                        clear_errors,
    output logic                        spi_start,
    output logic [NUMBER_OF_MOTORS-1:0] ss_n_o,
    output logic [IW-1:0]               motor_index,
    output logic                        round_busy,
    output logic                        frame_done,
    output logic                        timeout_error,
    output logic [IW-1:0]               error_motor,
    output logic                        overrun
);
    localparam int N    = NUMBER_OF_MOTORS;
    localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ?
                          ((TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES) :
                          ((GAP_CYCLES > SETUP_CYCLES) ? GAP_CYCLES : SETUP_CYCLES);
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] C_SETUP_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] C_TIMEOUT    = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        START   = 3'd2,
        XFER    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t          r_state;
    logic [31:0]     r_period_cnt;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_mask;
    logic            w_tick;
    logic [IW-1:0]   w_first_idx;
    logic [IW-1:0]   w_next_idx;
    logic            w_next_found;

    // Active-low select pattern with only the addressed board pulled low.
    function automatic logic [N-1:0] select_n(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v = {N{1'b1}};
        v[idx] = 1'b0;
        return v;
    endfunction

    // Period tick fires on the wrap cycle; a shrunk period wraps at once.
    always_comb begin
        w_tick = 1'b0;
        if (enable && (update_period != 32'd0)) begin
            w_tick = (r_period_cnt >= (update_period - 32'd1));
        end else begin
            w_tick = 1'b0;
        end
    end

    // Lowest enabled motor for a new round, next higher one in the latched mask.
    always_comb begin
        w_first_idx  = '0;
        w_next_idx   = '0;
        w_next_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            w_first_idx = motor_mask[i] ? IW'(i) : w_first_idx;
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (r_mask[i] && (IW'(i) > motor_index)) begin
                w_next_found = 1'b1;
                w_next_idx   = IW'(i);
            end else begin
                w_next_found = w_next_found;
            end
        end
    end

    // Period counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_period_cnt <= 32'd0;
        end else if (!enable || (update_period == 32'd0) || w_tick) begin
            r_period_cnt <= 32'd0;
        end else begin
            r_period_cnt <= r_period_cnt + 32'd1;
        end
    end

    // Poll sequencer with registered outputs and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_mask        <= '0;
            spi_start     <= 1'b0;
            ss_n_o        <= {N{1'b1}};
            motor_index   <= '0;
            round_busy    <= 1'b0;
            frame_done    <= 1'b0;
            timeout_error <= 1'b0;
            error_motor   <= '0;
            overrun       <= 1'b0;
        end else begin
            spi_start  <= 1'b0;
            frame_done <= 1'b0;
            // Set events below override a coincident clear.
            if (clear_errors) begin
                timeout_error <= 1'b0;
                overrun       <= 1'b0;
            end
            if (w_tick && round_busy) begin
                overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    ss_n_o <= {N{1'b1}};
                    if (w_tick && !power_sense_n && (motor_mask != '0)) begin
                        r_mask      <= motor_mask;
                        motor_index <= w_first_idx;
                        ss_n_o      <= select_n(w_first_idx);
                        round_busy  <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (r_cnt >= C_SETUP_LAST) begin
                        spi_start <= 1'b1;
                        r_state   <= START;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                START: begin
                    r_cnt   <= CW'(1);
                    r_state <= XFER;
                end
                XFER: begin
                    // r_cnt holds cycles elapsed since the start pulse; done wins a tie.
                    if (spi_done) begin
                        ss_n_o  <= {N{1'b1}};
                        r_cnt   <= '0;
                        r_state <= RELEASE;
                    end else if (r_cnt >= C_TIMEOUT) begin
                        timeout_error <= 1'b1;
                        error_motor   <= motor_index;
                        ss_n_o        <= {N{1'b1}};
                        r_cnt         <= '0;
                        r_state       <= RELEASE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (r_cnt >= C_GAP_LAST) begin
                        if (!enable || power_sense_n) begin
                            round_busy <= 1'b0;
                            r_state    <= IDLE;
                        end else if (w_next_found) begin
                            motor_index <= w_next_idx;
                            ss_n_o      <= select_n(w_next_idx);
                            r_cnt       <= '0;
                            r_state     <= SELECT;
                        end else begin
                            round_busy <= 1'b0;
                            frame_done <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    ss_n_o     <= {N{1'b1}};
                    round_busy <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Self-checking bench for myo_spi_scheduler: select-order scoreboard, SPI done responder,
// table-driven rounds and hand-written timeout, power-loss, overrun, idle and reset sequences.
module tb_myo_spi_scheduler;
    localparam int N     = 9;
    localparam int SETUP = 4;
    localparam int GAP   = 50;
    localparam int TMO   = 2000;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] motor_mask;
    logic [31:0]  update_period;
    logic         power_sense_n;
    logic         spi_done;
    logic         clear_errors;
    logic         spi_start;
    logic [N-1:0] ss_n_o;
    logic [3:0]   motor_index;
    logic         round_busy;
    logic         frame_done;
    logic         timeout_error;
    logic [3:0]   error_motor;
    logic         overrun;

    myo_spi_scheduler dut (
        .clock(clock), .reset(reset), .enable(enable), .motor_mask(motor_mask),
        .update_period(update_period), .power_sense_n(power_sense_n), .spi_done(spi_done),
        .clear_errors(clear_errors), .spi_start(spi_start), .ss_n_o(ss_n_o),
        .motor_index(motor_index), .round_busy(round_busy), .frame_done(frame_done),
        .timeout_error(timeout_error), .error_motor(error_motor), .overrun(overrun)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_delay = 0;
    logic [N-1:0] exp_q[$];
    int round_start_q[$];
    int n_sel, n_frame, n_start, sel_cyc, rel_cyc, start_cyc;
    logic [N-1:0] prev_ss;
    logic prev_busy;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard for select events plus setup/gap timing.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            round_start_q.delete();
            n_sel = 0; n_frame = 0; n_start = 0;
            sel_cyc = 0; rel_cyc = 0; start_cyc = 0;
            prev_ss = '1; prev_busy = 1'b0;
        end else begin
            if (ss_n_o !== prev_ss) begin
                check("ss_onehot", 32'($countones(~ss_n_o) <= 1), 32'd1);
                if (ss_n_o != '1) begin
                    check("select_while_busy", 32'(round_busy), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_select: ss_n_o=%h with none expected (cycle %0d)", ss_n_o, cyc);
                    end else begin
                        logic [N-1:0] e;
                        int idx;
                        e = exp_q.pop_front();
                        idx = 0;
                        for (int i = 0; i < N; i++) if (!e[i]) idx = i;
                        check("select_ss_n", 32'(ss_n_o), 32'(e));
                        check("select_index", 32'(motor_index), idx);
                    end
                    if (prev_busy) check("gap_cycles", cyc - rel_cyc, GAP);
                    else round_start_q.push_back(cyc);
                    sel_cyc = cyc;
                    n_sel++;
                end else begin
                    rel_cyc = cyc;
                end
            end
            if (spi_start) begin
                check("setup_cycles", cyc - sel_cyc, SETUP);
                start_cyc = cyc;
                n_start++;
            end
            if (frame_done) n_frame++;
            prev_ss = ss_n_o;
            prev_busy = round_busy;
        end
    end

    // SPI master model: one-cycle done pulse done_delay cycles after start (0 = never).
    initial begin
        spi_done = 1'b0;
        forever begin
            @(negedge clock);
            if (spi_start && !reset && done_delay > 0) begin
                repeat (done_delay) @(negedge clock);
                spi_done = 1'b1;
                @(negedge clock);
                spi_done = 1'b0;
            end
        end
    end

    task automatic push_round(input logic [N-1:0] m);
        logic [N-1:0] t;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                t = '1;
                t[i] = 1'b0;
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; motor_mask = '0; update_period = 32'd0;
        power_sense_n = 1'b1; clear_errors = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input int bound, input string name);
        int n = 0;
        while (round_busy !== lvl && n < bound) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(n < bound), 32'd1);
    endtask

    task automatic wait_round(input int bound, input string name);
        wait_level(1'b1, bound, name);
        wait_level(1'b0, bound, name);
        repeat (2) @(negedge clock);
    endtask

    task automatic wait_start(input int idx, input int bound);
        int n = 0;
        while (!(spi_start && motor_index == 4'(idx)) && n < bound) begin
            @(negedge clock);
            n++;
        end
        check("wait_start", 32'(n < bound), 32'd1);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        @(negedge clock);
    endtask

    typedef struct { logic [N-1:0] mask; int exp_sel; int exp_frames; } vec_t;
    typedef struct { logic en; logic [31:0] period; logic [N-1:0] mask; } idle_t;
    vec_t  vt[5];
    idle_t it[3];

    initial begin
        int c0;
        vt[0] = '{9'b000000101, 2, 1};
        vt[1] = '{9'h1FF,       9, 1};
        vt[2] = '{9'h100,       1, 1};
        vt[3] = '{9'h001,       1, 1};
        vt[4] = '{9'b010101010, 4, 1};
        it[0] = '{1'b1, 32'd1000, 9'h000};
        it[1] = '{1'b1, 32'd0,    9'h1FF};
        it[2] = '{1'b0, 32'd1000, 9'h1FF};

        // Reset state
        do_reset();
        @(negedge clock);
        check("rst_ss_n", 32'(ss_n_o), 32'h1FF);
        check("rst_start", 32'(spi_start), 32'd0);
        check("rst_busy", 32'(round_busy), 32'd0);
        check("rst_frame", 32'(frame_done), 32'd0);
        check("rst_timeout", 32'(timeout_error), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_index", 32'(motor_index), 32'd0);
        check("rst_err_motor", 32'(error_motor), 32'd0);

        // Table-driven single rounds; the live mask is flipped after the first start.
        foreach (vt[v]) begin
            do_reset();
            done_delay = 20;
            update_period = 32'd1000;
            motor_mask = vt[v].mask;
            power_sense_n = 1'b0;
            push_round(vt[v].mask);
            enable = 1'b1;
            c0 = cyc;
            wait_level(1'b1, 1500, "tbl_wait_busy");
            wait_start(int'(motor_index), 100);
            motor_mask = ~vt[v].mask;
            wait_round(1500, "tbl_wait_round");
            enable = 1'b0;
            check("tbl_selects", n_sel, vt[v].exp_sel);
            check("tbl_frames", n_frame, vt[v].exp_frames);
            check("tbl_queue_empty", exp_q.size(), 0);
            check("tbl_timeout_flag", 32'(timeout_error), 32'd0);
            check("tbl_rounds", round_start_q.size(), 1);
            if (round_start_q.size() > 0) check("tbl_first_round_delay", round_start_q[0] - c0, 1000);
        end

        // Basic round repeated: rounds start exactly one period apart
        do_reset();
        done_delay = 20; update_period = 32'd1000; motor_mask = 9'b000000101; power_sense_n = 1'b0;
        push_round(9'b000000101);
        push_round(9'b000000101);
        enable = 1'b1;
        wait_round(1500, "basic_round1");
        wait_round(1500, "basic_round2");
        enable = 1'b0;
        check("basic_frames", n_frame, 2);
        check("basic_rounds", round_start_q.size(), 2);
        if (round_start_q.size() == 2) check("basic_period", round_start_q[1] - round_start_q[0], 1000);

        // Timeout, and the done-on-final-cycle boundary on both sides
        for (int k = 0; k < 3; k++) begin
            int dl[3] = '{0, TMO, TMO + 1};
            int te[3] = '{1, 0, 1};
            do_reset();
            done_delay = dl[k]; update_period = 32'd2500; motor_mask = 9'b000010000; power_sense_n = 1'b0;
            push_round(9'b000010000);
            enable = 1'b1;
            wait_round(5000, "tmo_wait_round");
            enable = 1'b0;
            check("tmo_flag", 32'(timeout_error), 32'(te[k]));
            check("tmo_release_cycle", rel_cyc - start_cyc, TMO + 1);
            check("tmo_frames", n_frame, 1);
            check("tmo_ss_n", 32'(ss_n_o), 32'h1FF);
            if (k == 0) begin
                check("tmo_err_motor", 32'(error_motor), 32'd4);
                pulse_clear();
                check("tmo_cleared", 32'(timeout_error), 32'd0);
            end
        end

        // Power loss during motor 2 transfer
        do_reset();
        done_delay = 20; update_period = 32'd2000; motor_mask = 9'h1FF; power_sense_n = 1'b0;
        push_round(9'h007);
        enable = 1'b1;
        wait_start(2, 2500);
        power_sense_n = 1'b1;
        wait_level(1'b0, 500, "pwr_wait_idle");
        repeat (2100) @(negedge clock);
        check("pwr_selects", n_sel, 3);
        check("pwr_frames", n_frame, 0);
        check("pwr_busy", 32'(round_busy), 32'd0);
        check("pwr_queue_empty", exp_q.size(), 0);

        // Overrun: ticks during a 150-cycle round are dropped
        do_reset();
        done_delay = 20; update_period = 32'd50; motor_mask = 9'b000000011; power_sense_n = 1'b0;
        push_round(9'b000000011);
        push_round(9'b000000001);
        enable = 1'b1;
        wait_round(500, "ovr_round1");
        check("ovr_flag", 32'(overrun), 32'd1);
        wait_level(1'b1, 200, "ovr_round2_start");
        enable = 1'b0;
        wait_level(1'b0, 500, "ovr_round2_end");
        repeat (2) @(negedge clock);
        check("ovr_frames", n_frame, 1);
        check("ovr_queue_empty", exp_q.size(), 0);
        check("ovr_rounds", round_start_q.size(), 2);
        if (round_start_q.size() == 2) check("ovr_restart_delay", round_start_q[1] - round_start_q[0], 200);
        pulse_clear();
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Idle cases
        foreach (it[j]) begin
            do_reset();
            done_delay = 20; power_sense_n = 1'b0;
            enable = it[j].en; update_period = it[j].period; motor_mask = it[j].mask;
            repeat (10000) @(negedge clock);
            check("idle_starts", n_start, 0);
            check("idle_ss_n", 32'(ss_n_o), 32'h1FF);
            check("idle_flags", {30'd0, timeout_error, overrun}, 32'd0);
        end

        // Asynchronous reset mid-transfer
        do_reset();
        done_delay = 20; update_period = 32'd1000; motor_mask = 9'b000000101; power_sense_n = 1'b0;
        push_round(9'b000000101);
        enable = 1'b1;
        wait_start(0, 1500);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("areset_ss_n", 32'(ss_n_o), 32'h1FF);
        check("areset_start", 32'(spi_start), 32'd0);
        check("areset_busy", 32'(round_busy), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        c0 = cyc;
        push_round(9'b000000101);
        wait_round(1500, "areset_round");
        enable = 1'b0;
        check("areset_rounds", round_start_q.size(), 1);
        if (round_start_q.size() > 0) check("areset_first_select", round_start_q[0] - c0, 1000);
        check("areset_frames", n_frame, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
